serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow flag when SERIAL_SUB_OVF_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_brw;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_d;
    logic             w_brw_next;
    logic [WIDTH-1:0] w_diff_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSB pair.
    assign w_d        = r_a_sh[0] ^ r_b_sh[0] ^ r_brw;
    assign w_brw_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_brw);

    // Difference bits enter the minuend register from the top as its bits are consumed.
    assign w_diff_next = {w_d, r_a_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_brw  <= bin;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_a_sh <= w_diff_next;
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_brw  <= w_brw_next;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_last) begin
            r_diff <= w_diff_next;
            r_bout <= w_brw_next;
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the last bit, r_brw is the borrow into the MSB stage and w_brw_next is bout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_brw ^ w_brw_next;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire
